// File: rtl/branch_resolve_unit_pkg.sv
// Shared constants for the branch resolve unit: condition encodings and the
// predictor counter reset value.
package branch_resolve_unit_pkg;

    localparam logic [2:0] COND_NONE = 3'b000;
    localparam logic [2:0] COND_BEQ  = 3'b001;
    localparam logic [2:0] COND_BNE  = 3'b010;
    localparam logic [2:0] COND_BLTZ = 3'b011;
    localparam logic [2:0] COND_BGEZ = 3'b100;
    localparam logic [2:0] COND_BLEZ = 3'b101;
    localparam logic [2:0] COND_BGTZ = 3'b110;
    localparam logic [2:0] COND_JUMP = 3'b111;

    // Weakly not-taken
    localparam logic [1:0] CTR_INIT = 2'b01;

endpackage

// File: rtl/branch_resolve_unit_cond_eval.sv
// Combinational branch condition evaluator: derives zero/negative flags from
// the ALU result and selects the outcome for the given condition code.
module branch_cond_eval
    import branch_resolve_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] alu_result,
    input  logic [2:0]        res_cond,
    output logic              taken
);

    logic zero;
    logic neg;

    assign zero = (alu_result == '0);
    assign neg  = alu_result[DATA_W-1];

    always_comb begin
        taken = 1'b0;
        case (res_cond)
            COND_NONE: taken = 1'b0;
            COND_BEQ:  taken = zero;
            COND_BNE:  taken = !zero;
            COND_BLTZ: taken = neg;
            COND_BGEZ: taken = !neg;
            COND_BLEZ: taken = neg | zero;
            COND_BGTZ: taken = !neg & !zero;
            COND_JUMP: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: registers the branch decision, trains a table of 2-bit
// saturating predictors and keeps saturating resolve/mispredict statistics.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int PC_W      = 32,
    parameter int BHT_DEPTH = 16,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PC_W-1:0]   pred_pc,
    output logic              pred_taken,
    input  logic              res_valid,
    input  logic [PC_W-1:0]   res_pc,
    input  logic [2:0]        res_cond,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              res_pred_taken,
    output logic              br_taken,
    output logic              mispredict,
    output logic              done,
    output logic [CNT_W-1:0]  resolved_cnt,
    output logic [CNT_W-1:0]  mispredict_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]       bht [BHT_DEPTH];
    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] update_idx;
    logic             taken;
    logic             counted;
    logic             trains;
    logic             miss;
    logic             unused_pc;

    branch_cond_eval #(.DATA_W(DATA_W)) u_cond_eval (
        .alu_result (alu_result),
        .res_cond   (res_cond),
        .taken      (taken)
    );

    // Word-aligned PCs: the low two bits never select an entry
    assign lookup_idx = pred_pc[IDX_W+1:2];
    assign update_idx = res_pc[IDX_W+1:2];
    assign unused_pc  = ^{pred_pc, res_pc};

    assign pred_taken = bht[lookup_idx][1];

    // Unconditional jumps are counted and can mispredict but never train
    assign counted = res_valid && (res_cond != COND_NONE);
    assign trains  = counted && (res_cond != COND_JUMP);
    assign miss    = counted && (taken != res_pred_taken);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= CTR_INIT;
            end
        end else if (trains) begin
            if (taken && bht[update_idx] != 2'b11) begin
                bht[update_idx] <= bht[update_idx] + 2'b01;
            end else if (!taken && bht[update_idx] != 2'b00) begin
                bht[update_idx] <= bht[update_idx] - 2'b01;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_taken   <= 1'b0;
            mispredict <= 1'b0;
            done       <= 1'b0;
        end else begin
            br_taken   <= res_valid && taken;
            mispredict <= miss;
            done       <= res_valid;
        end
    end

    // Statistics hold at all-ones rather than wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resolved_cnt   <= '0;
            mispredict_cnt <= '0;
        end else begin
            if (counted && resolved_cnt != '1) begin
                resolved_cnt <= resolved_cnt + CNT_W'(1);
            end
            if (miss && mispredict_cnt != '1) begin
                mispredict_cnt <= mispredict_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard testbench for branch_resolve_unit: a reference model predicts each
// cycle's registered outputs, which a monitor pops and compares after the edge.
module tb_branch_resolve_unit;

    localparam int DATA_W = 32;
    localparam int PC_W   = 32;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 4;

    typedef struct {
        logic       br_taken;
        logic       mispredict;
        logic       done;
        logic [3:0] resolved_cnt;
        logic [3:0] mispredict_cnt;
    } expect_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [PC_W-1:0]   pred_pc = '0;
    logic              pred_taken;
    logic              res_valid = 1'b0;
    logic [PC_W-1:0]   res_pc = '0;
    logic [2:0]        res_cond = 3'b000;
    logic [DATA_W-1:0] alu_result = '0;
    logic              res_pred_taken = 1'b0;
    logic              br_taken;
    logic              mispredict;
    logic              done;
    logic [CNT_W-1:0]  resolved_cnt;
    logic [CNT_W-1:0]  mispredict_cnt;

    expect_t    sb_queue[$];
    logic [1:0] model_bht [DEPTH];
    logic [3:0] model_resolved;
    logic [3:0] model_mispred;
    int         checks = 0;
    int         errors = 0;

    branch_resolve_unit #(
        .DATA_W(DATA_W), .PC_W(PC_W), .BHT_DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pred_pc        (pred_pc),
        .pred_taken     (pred_taken),
        .res_valid      (res_valid),
        .res_pc         (res_pc),
        .res_cond       (res_cond),
        .alu_result     (alu_result),
        .res_pred_taken (res_pred_taken),
        .br_taken       (br_taken),
        .mispredict     (mispredict),
        .done           (done),
        .resolved_cnt   (resolved_cnt),
        .mispredict_cnt (mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic refTaken(input logic [2:0] cond, input logic [DATA_W-1:0] alu);
        logic signed [DATA_W-1:0] s;
        s = alu;
        case (cond)
            3'd1:    return s == 0;
            3'd2:    return s != 0;
            3'd3:    return s < 0;
            3'd4:    return s >= 0;
            3'd5:    return s <= 0;
            3'd6:    return s > 0;
            3'd7:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int tableIndex(input logic [PC_W-1:0] pc);
        return int'((pc / 4) % DEPTH);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) model_bht[i] = 2'b01;
        model_resolved = '0;
        model_mispred  = '0;
    endtask

    // Called at a falling edge; drives one cycle and queues its expected result
    task automatic applyStimulus(input logic valid, input logic [PC_W-1:0] pc, input logic [2:0] cond,
                                 input logic [DATA_W-1:0] alu, input logic ptaken, input logic [PC_W-1:0] lookup);
        expect_t e;
        logic    t;
        int      ui;
        res_valid      = valid;
        res_pc         = pc;
        res_cond       = cond;
        alu_result     = alu;
        res_pred_taken = ptaken;
        pred_pc        = lookup;
        #1;
        checkOutput("pred_taken", 32'(pred_taken), 32'(model_bht[tableIndex(lookup)][1]));
        t  = refTaken(cond, alu);
        ui = tableIndex(pc);
        e.br_taken   = valid && t;
        e.done       = valid;
        e.mispredict = valid && cond != 3'd0 && (t != ptaken);
        if (valid && cond != 3'd0 && model_resolved != 4'hF) model_resolved++;
        if (e.mispredict && model_mispred != 4'hF) model_mispred++;
        if (valid && cond != 3'd0 && cond != 3'd7) begin
            if (t && model_bht[ui] != 2'b11) model_bht[ui]++;
            else if (!t && model_bht[ui] != 2'b00) model_bht[ui]--;
        end
        e.resolved_cnt   = model_resolved;
        e.mispredict_cnt = model_mispred;
        sb_queue.push_back(e);
        @(negedge clk);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        res_valid = 1'b0;
        sb_queue.delete();
        modelReset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compare registered outputs shortly after each rising edge
    always @(posedge clk) begin
        expect_t e;
        #2;
        if (rst_n && sb_queue.size() > 0) begin
            e = sb_queue.pop_front();
            checkOutput("br_taken", 32'(br_taken), 32'(e.br_taken));
            checkOutput("mispredict", 32'(mispredict), 32'(e.mispredict));
            checkOutput("done", 32'(done), 32'(e.done));
            checkOutput("resolved_cnt", 32'(resolved_cnt), 32'(e.resolved_cnt));
            checkOutput("mispredict_cnt", 32'(mispredict_cnt), 32'(e.mispredict_cnt));
        end
    end

    initial begin
        logic [DATA_W-1:0] sweep_vals [3];
        sweep_vals[0] = 32'h0;
        sweep_vals[1] = 32'h5;
        sweep_vals[2] = 32'hFFFF_FFFF;
        modelReset();
        @(negedge clk);
        doReset();

        $display("[TB] reset state");
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_br_taken", 32'(br_taken), 32'd0);
        checkOutput("rst_resolved_cnt", 32'(resolved_cnt), 32'd0);
        checkOutput("rst_mispredict_cnt", 32'(mispredict_cnt), 32'd0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, '0, 3'd0, '0, 1'b0, PC_W'(i * 4 + 1));

        $display("[TB] BEQ taken at 0x40, predicted not-taken");
        applyStimulus(1'b1, 32'h40, 3'd1, 32'h0, 1'b0, 32'h40);
        checkOutput("beq_mispredict_cnt", 32'(mispredict_cnt), 32'd1);
        checkOutput("beq_entry0_pred", 32'(pred_taken), 32'd1);
        applyStimulus(1'b0, '0, 3'd0, '0, 1'b0, 32'h00);

        $display("[TB] condition sweep");
        for (int c = 0; c < 8; c++) begin
            for (int v = 0; v < 3; v++) begin
                applyStimulus(1'b1, PC_W'(32'h100 + (c * 3 + v) * 4), 3'(c), sweep_vals[v],
                              1'($urandom_range(0, 1)), PC_W'(32'h100 + v * 4));
            end
        end
        applyStimulus(1'b0, '0, 3'd0, '0, 1'b0, 32'h0);
        doReset();

        $display("[TB] predictor saturation");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h08, 3'd2, 32'h1, 1'b1, 32'h08);
        applyStimulus(1'b0, '0, 3'd0, '0, 1'b0, 32'h08);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h08, 3'd2, 32'h0, 1'b0, 32'h08);
        applyStimulus(1'b0, '0, 3'd0, '0, 1'b0, 32'h08);

        $display("[TB] same-cycle lookup and update");
        applyStimulus(1'b1, 32'h10, 3'd1, 32'h0, 1'b1, 32'h10);
        applyStimulus(1'b0, '0, 3'd0, '0, 1'b0, 32'h10);
        doReset();

        $display("[TB] statistics saturation");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, PC_W'(i * 4), (i % 2 == 0) ? 3'd4 : 3'd7, 32'h5, (i % 3 == 0) ? 1'b0 : 1'b1, PC_W'(i * 4));
        end
        applyStimulus(1'b0, '0, 3'd0, '0, 1'b0, 32'h0);
        checkOutput("sat_resolved_cnt", 32'(resolved_cnt), 32'd15);
        doReset();

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 32'h20, 3'd1, 32'h0, 1'b1, 32'h20);
        checkOutput("pre_reset_pred", 32'(pred_taken), 32'd1);
        applyStimulus(1'b1, 32'h20, 3'd7, 32'h0, 1'b0, 32'h20);
        #1;
        rst_n = 1'b0;
        res_valid = 1'b0;
        sb_queue.delete();
        modelReset();
        #1;
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_mispredict", 32'(mispredict), 32'd0);
        checkOutput("midrst_br_taken", 32'(br_taken), 32'd0);
        checkOutput("midrst_resolved_cnt", 32'(resolved_cnt), 32'd0);
        checkOutput("midrst_table", 32'(pred_taken), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, '0, 3'd0, '0, 1'b0, 32'h20);
        applyStimulus(1'b0, '0, 3'd0, '0, 1'b0, 32'h20);

        checkOutput("queue_drain", 32'(sb_queue.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
